alu_dispatch: RTL

ALU_DISPATCH -- requirements
Module: alu_dispatch

---
 rtl/alu_dispatch.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/alu_dispatch.sv
// RV32I R/I/B dispatch sequencer: decodes one instruction, drives the ALU for RESULT_LAT cycles, then captures the result.
// Optional macro ALU_DISPATCH_PERF_EN enables the saturating op/taken performance counters.
module alu_dispatch #(
  parameter int RESULT_LAT = 5
) (
  input  logic        soc_clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs1_dat,
  input  logic [31:0] rs2_dat,
  output logic [31:0] ALU_dat1,
  output logic [31:0] ALU_dat2,
  output logic [2:0]  ALU_opcode,
  output logic        ALU_opcode_differentiator,
  output logic        ALU_optype,
  output logic        dat_ready,
  input  logic [31:0] ALU_out,
  input  logic        ALU_overflow,
  input  logic        ALU_con_met,
  input  logic        ALU_zero,
  input  logic        ALU_err,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_dat,
  output logic        branch_valid,
  output logic        branch_taken,
  output logic        dispatch_err,
  output logic        ovf_flag,
  output logic        zero_flag,
  output logic [15:0] op_count,
  output logic [15:0] taken_count
);

  // state | meaning
  // IDLE  | ready for an instruction
  // SETUP | operands driven, dat_ready still low
  // WAIT  | dat_ready high, counting toward RESULT_LAT
  // DONE  | result pulses visible for one cycle
  typedef enum logic [1:0] {IDLE, SETUP, WAIT, DONE} state_t;

  localparam int CW = (RESULT_LAT < 2) ? 1 : $clog2(RESULT_LAT + 1);
  localparam logic [CW-1:0] LAT = CW'(RESULT_LAT);

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_B = 7'b1100011;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [4:0]    rd_q;
  logic          is_r, is_i, is_b, legal, shift_imm;
  logic [31:0]   dat2_dec;
  logic          diff_dec;
  logic          capture;
  logic          unused_rs1_field;

  assign is_r      = (instr[6:0] == OP_R);
  assign is_i      = (instr[6:0] == OP_I);
  assign is_b      = (instr[6:0] == OP_B);
  assign legal     = is_r | is_i | is_b;
  assign shift_imm = (instr[13:12] == 2'b01);
  assign unused_rs1_field = ^instr[19:15];

  assign instr_ready = (state == IDLE);
  assign capture     = (state == WAIT) && (cnt == LAT);

  always_comb begin
    dat2_dec = rs2_dat;
    diff_dec = 1'b0;
    if (is_r) begin
      diff_dec = instr[30];
    end else if (is_i) begin
      if (shift_imm) begin
        dat2_dec = {27'b0, instr[24:20]};
        diff_dec = instr[30];
      end else begin
        dat2_dec = {{20{instr[31]}}, instr[31:20]};
      end
    end
  end

  always_ff @(posedge soc_clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (instr_valid && legal) state_nxt = SETUP;
      SETUP:   state_nxt = WAIT;
      WAIT:    if (cnt == LAT) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge soc_clk) begin
    if (!reset) begin
      ALU_dat1                  <= '0;
      ALU_dat2                  <= '0;
      ALU_opcode                <= '0;
      ALU_opcode_differentiator <= 1'b0;
      ALU_optype                <= 1'b0;
      dat_ready                 <= 1'b0;
      cnt                       <= '0;
      rd_q                      <= '0;
      wb_valid                  <= 1'b0;
      wb_rd                     <= '0;
      wb_dat                    <= '0;
      branch_valid              <= 1'b0;
      branch_taken              <= 1'b0;
      dispatch_err              <= 1'b0;
      ovf_flag                  <= 1'b0;
      zero_flag                 <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      branch_valid <= 1'b0;
      branch_taken <= 1'b0;
      dispatch_err <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            if (legal) begin
              ALU_dat1                  <= rs1_dat;
              ALU_dat2                  <= dat2_dec;
              ALU_opcode                <= instr[14:12];
              ALU_opcode_differentiator <= diff_dec;
              ALU_optype                <= is_b;
              rd_q                      <= instr[11:7];
            end else begin
              dispatch_err <= 1'b1;
            end
          end
        end
        SETUP: begin
          dat_ready <= 1'b1;
          cnt       <= CW'(1);
        end
        WAIT: begin
          if (capture) begin
            dat_ready <= 1'b0;
            if (ALU_err) begin
              dispatch_err <= 1'b1;
            end else if (ALU_optype) begin
              branch_valid <= 1'b1;
              branch_taken <= ALU_con_met;
            end else begin
              wb_valid  <= (rd_q != 5'd0);
              wb_rd     <= rd_q;
              ovf_flag  <= ALU_overflow;
              zero_flag <= ALU_zero;
              // SLT/SLTU report the comparison via con_met rather than ALU_out
              if (ALU_opcode[2:1] == 2'b01) wb_dat <= {31'b0, ALU_con_met};
              else                          wb_dat <= ALU_out;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ALU_DISPATCH_PERF_EN
  always_ff @(posedge soc_clk) begin
    if (!reset) begin
      op_count    <= '0;
      taken_count <= '0;
    end else if (capture) begin
      if (op_count != 16'hFFFF) op_count <= op_count + 16'd1;
      if (!ALU_err && ALU_optype && ALU_con_met && (taken_count != 16'hFFFF))
        taken_count <= taken_count + 16'd1;
    end
  end
`else
  assign op_count    = '0;
  assign taken_count = '0;
`endif

endmodule
